mac_rx_frame_demux: RTL and testbench
=====================================

# mac_rx_frame_demux

Receive-side Ethernet frame demultiplexer in the `logic_clk` domain, fed directly by the MAC RX CRC-verify FIFO output stream. It strips the 14-byte Ethernet header and the 4-byte FCS, and captures the source MAC. It routes the remaining payload to an IP or an ARP AXI-Stream-style byte port according to the frame type tag. Frames with an unknown type and runt frames are consumed and dropped, and each drop is flagged.

## Interface
- `ETH_HEAD_LENGTH`, 14, header bytes stripped before the payload.
- `FCS_LENGTH`, 4, trailing bytes withheld from the payload outputs.
- `logic_clk`  in  1  sole clock.
- `logic_rst_n`  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- `mac_rdata_in`  in  8  frame byte, first byte is destination MAC byte 0, last byte is FCS byte 3.
- `mac_rvalid_in`  in  1  input byte valid.
- `mac_rready_out`  out  1  input byte accepted when high together with `mac_rvalid_in`.
- `mac_rlast_in`  in  1  marks the final FCS byte.
- `mac_rtype_in`  in  2  `[1]` IP, `[0]` ARP; constant across a frame.
- `ip_rdata_out`  out  8  IP payload byte.
- `ip_rvalid_out`  out  1  IP byte valid.
- `ip_rready_in`  in  1  IP sink ready.
- `ip_rlast_out`  out  1  last IP payload byte.
- `arp_rdata_out`, `arp_rvalid_out`, `arp_rready_in`, `arp_rlast_out`: same as the IP port, for the ARP path.
- `frame_src_mac_out`  out  48  source MAC, first received byte in bits [47:40].
- `frame_info_valid_out`  out  1  one-cycle pulse when `frame_src_mac_out` is updated.
- `frame_drop_out`  out  1  one-cycle pulse per dropped frame.

## Operation
- FSM states: HEAD, PAYLOAD, DROP. The reset state is HEAD.
- **HEAD**
  - `mac_rready_out` = 1. A byte counter counts accepted bytes 0..13.
  - At byte 0, latch the route: `2'b10` → IP, `2'b01` → ARP, anything else (including `2'b11`) → drop.
  - Bytes 6..11 shift into `frame_src_mac_out`.
  - At byte 13: pulse `frame_info_valid_out`, then go to PAYLOAD, or to DROP if the route is drop.
  - `mac_rlast_in` accepted while in HEAD: pulse `frame_drop_out`, clear the counter, stay in HEAD.
- **PAYLOAD**
  - Accepted bytes enter a 4-entry FCS delay line.
  - When a byte is accepted with the line full, the oldest entry moves to the selected output register.
  - If the incoming byte carries `mac_rlast_in`, the moved byte is marked last. The line is then cleared and the FSM returns to HEAD.
  - `mac_rlast_in` arriving while the line holds fewer than 4 bytes means nothing in the frame was emitted. In that case: pulse `frame_drop_out`, clear the line, go to HEAD.
  - `mac_rready_out` = !(line full && selected output valid && !selected ready).
- **DROP**
  - `mac_rready_out` = 1; every byte is discarded.
  - On the accepted `mac_rlast_in`: pulse `frame_drop_out`, go to HEAD.
- The non-selected output port stays idle.
- An output register holds its data, valid and last stable until its ready is seen high.
- Back-to-back frames with no idle cycle are supported. The HEAD-state counter restarts on the cycle after the last byte.

## Timing
- Every output resets to 0: all data, valid, last, `frame_src_mac_out`, and both pulses. `mac_rready_out` is 0 while reset is asserted and 1 in the first cycle after release.
- Payload byte k appears on its output one cycle after payload-region byte k+4 is accepted. Throughput is one byte per cycle with ready high.
- `frame_info_valid_out` pulses in the cycle after byte 13 is accepted.
- `frame_drop_out` pulses in the cycle after the dropping `mac_rlast_in` is accepted.
- A simultaneous output handshake and new byte arrival refills the output register in the same cycle, with no bubble.
- Reset asserted mid-frame: outputs clear asynchronously. After release, parsing restarts in HEAD; the upstream FIFO shares this reset.

## Structure
- `mac_pkg` holds `ETH_HEAD_LENGTH`, `FCS_LENGTH`, the `mac_rtype` bit indices, and the state enum typedef.
- One sub-module, `mac_rx_fcs_strip`, contains the 4-entry delay line, last-byte regeneration and the runt flag, with a valid/ready stream on both sides.
- The top level holds the FSM, header capture and output steering.

## Test plan
- IP frame of 14 header + 46 payload (0x00..0x2D) + 4 FCS bytes, type `2'b10`, ready high → 46 bytes 0x00..0x2D on IP with last on 0x2D. `frame_src_mac_out` = 0x001122334455. ARP port idle.
- ARP frame with type `2'b01` and a 28-byte payload → 28 bytes on ARP, last on byte 27, no IP activity.
- The IP frame above with `ip_rready_in` toggling every cycle → same 46 bytes in order. `mac_rready_out` drops while the output stalls; no loss, no duplication.
- Type `2'b00` frame, 64 bytes → all 64 accepted, one `frame_drop_out` pulse, no output valid.
- Runt frames of 16 bytes (type IP) and of 10 bytes → one drop pulse each. No payload output; 10-byte case gives no `frame_info_valid_out` pulse, 16-byte case gives one.
- Reset asserted at payload byte 20, then a clean 64-byte IP frame → outputs 0 during reset, and the new frame is delivered complete.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the MAC receive frame demultiplexer.
package mac_pkg;

  localparam int ETH_HEAD_LENGTH = 14;
  localparam int FCS_LENGTH      = 4;

  // Bit positions inside mac_rtype_in.
  localparam int RTYPE_IP_BIT  = 1;
  localparam int RTYPE_ARP_BIT = 0;

  typedef enum logic [1:0] {
    ST_HEAD    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } mac_rx_state_e;

endpackage

// File: rtl/mac_rx_fcs_strip.sv
// Withholds the trailing FCS bytes of a payload stream through a short delay line and
// re-marks the last emitted byte; flags frames that end before anything was emitted.
module mac_rx_fcs_strip
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  input  logic       in_user,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_user,
  output logic       frame_end,
  output logic       runt
);

  localparam int CW = $clog2(FCS_LENGTH + 1);
  localparam logic [CW-1:0] FILL_FULL = CW'(FCS_LENGTH);

  logic [7:0]    line_q [FCS_LENGTH];
  logic [CW-1:0] fill_q;
  logic          full;
  logic          accept;

  // A stalled output register with a full line blocks the input; a byte moving out while
  // the register hands off in the same cycle refills it without a bubble.
  assign full      = (fill_q == FILL_FULL);
  assign in_ready  = !(full && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && in_last;
  assign runt      = frame_end && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FCS_LENGTH; i++) line_q[i] <= '0;
      fill_q <= '0;
    end else if (accept) begin
      line_q[0] <= in_data;
      for (int i = 1; i < FCS_LENGTH; i++) line_q[i] <= line_q[i-1];
      if (in_last)
        fill_q <= '0;
      else if (!full)
        fill_q <= fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (accept && full) begin
      out_data  <= line_q[FCS_LENGTH-1];
      out_last  <= in_last;
      out_user  <= in_user;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_rx_frame_demux.sv
// Parses the Ethernet header of each received frame, captures the source MAC and steers
// the FCS-stripped payload to the IP or ARP byte port; unknown types and runts are dropped.
module mac_rx_frame_demux
  import mac_pkg::*;
(
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [7:0]  mac_rdata_in,
  input  logic        mac_rvalid_in,
  output logic        mac_rready_out,
  input  logic        mac_rlast_in,
  input  logic [1:0]  mac_rtype_in,
  output logic [7:0]  ip_rdata_out,
  output logic        ip_rvalid_out,
  input  logic        ip_rready_in,
  output logic        ip_rlast_out,
  output logic [7:0]  arp_rdata_out,
  output logic        arp_rvalid_out,
  input  logic        arp_rready_in,
  output logic        arp_rlast_out,
  output logic [47:0] frame_src_mac_out,
  output logic        frame_info_valid_out,
  output logic        frame_drop_out,
  output logic [1:0]  fsm_state_dbg
);

  localparam logic [3:0] HDR_LAST  = 4'(ETH_HEAD_LENGTH - 1);
  localparam logic [3:0] SRC_FIRST = 4'd6;
  localparam logic [3:0] SRC_LAST  = 4'd11;

  mac_rx_state_e state_q;
  logic [3:0]    hdr_cnt_q;
  logic          route_ip_q;
  logic          route_drop_q;
  logic [47:0]   src_mac_q;
  logic          info_q;
  logic          drop_q;
  logic          type_ip;
  logic          type_arp;
  logic          rready_int;
  logic          mac_accept;

  logic       strip_in_valid;
  logic       strip_in_ready;
  logic [7:0] strip_out_data;
  logic       strip_out_valid;
  logic       strip_out_ready;
  logic       strip_out_last;
  logic       strip_out_user;
  logic       strip_frame_end;
  logic       strip_runt;

  // Every stream here transfers a byte on a rising clock edge where valid and ready are both
  // high; a source holds data/last/valid stable until that edge, a sink may drop ready freely.
  assign type_ip  = mac_rtype_in[RTYPE_IP_BIT] && !mac_rtype_in[RTYPE_ARP_BIT];
  assign type_arp = mac_rtype_in[RTYPE_ARP_BIT] && !mac_rtype_in[RTYPE_IP_BIT];

  always_comb begin
    rready_int = 1'b1;
    if (state_q == ST_PAYLOAD) rready_int = strip_in_ready;
  end

  assign mac_rready_out = logic_rst_n && rready_int;
  assign mac_accept     = mac_rvalid_in && mac_rready_out;
  assign strip_in_valid = mac_rvalid_in && (state_q == ST_PAYLOAD);

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q      <= ST_HEAD;
      hdr_cnt_q    <= '0;
      route_ip_q   <= 1'b0;
      route_drop_q <= 1'b0;
      src_mac_q    <= '0;
      info_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      info_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        ST_HEAD: begin
          if (mac_accept) begin
            if (mac_rlast_in) begin
              drop_q    <= 1'b1;
              hdr_cnt_q <= '0;
            end else begin
              if (hdr_cnt_q == 4'd0) begin
                route_ip_q   <= type_ip;
                route_drop_q <= !(type_ip || type_arp);
              end
              if (hdr_cnt_q >= SRC_FIRST && hdr_cnt_q <= SRC_LAST)
                src_mac_q <= {src_mac_q[39:0], mac_rdata_in};
              if (hdr_cnt_q == HDR_LAST) begin
                info_q    <= 1'b1;
                hdr_cnt_q <= '0;
                state_q   <= route_drop_q ? ST_DROP : ST_PAYLOAD;
              end else begin
                hdr_cnt_q <= hdr_cnt_q + 4'd1;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (strip_frame_end) begin
            drop_q  <= strip_runt;
            state_q <= ST_HEAD;
          end
        end
        ST_DROP: begin
          if (mac_accept && mac_rlast_in) begin
            drop_q  <= 1'b1;
            state_q <= ST_HEAD;
          end
        end
        default: state_q <= ST_HEAD;
      endcase
    end
  end

  mac_rx_fcs_strip u_fcs_strip (
    .clk       (logic_clk),
    .rst_n     (logic_rst_n),
    .in_data   (mac_rdata_in),
    .in_valid  (strip_in_valid),
    .in_ready  (strip_in_ready),
    .in_last   (mac_rlast_in),
    .in_user   (route_ip_q),
    .out_data  (strip_out_data),
    .out_valid (strip_out_valid),
    .out_ready (strip_out_ready),
    .out_last  (strip_out_last),
    .out_user  (strip_out_user),
    .frame_end (strip_frame_end),
    .runt      (strip_runt)
  );

  // The route travels with the held byte, so a new frame's header cannot re-steer it.
  assign strip_out_ready = strip_out_user ? ip_rready_in : arp_rready_in;

  assign ip_rvalid_out  = strip_out_valid && strip_out_user;
  assign ip_rdata_out   = strip_out_user ? strip_out_data : 8'h00;
  assign ip_rlast_out   = strip_out_valid && strip_out_user && strip_out_last;
  assign arp_rvalid_out = strip_out_valid && !strip_out_user;
  assign arp_rdata_out  = strip_out_user ? 8'h00 : strip_out_data;
  assign arp_rlast_out  = strip_out_valid && !strip_out_user && strip_out_last;

  assign frame_src_mac_out    = src_mac_q;
  assign frame_info_valid_out = info_q;
  assign frame_drop_out       = drop_q;
  assign fsm_state_dbg        = state_q;

endmodule

// File: tb/tb_mac_rx_frame_demux.sv
// Randomized bench for mac_rx_frame_demux against a frame-level reference model.
module tb_mac_rx_frame_demux;

  localparam int HDR = 14;
  localparam int FCS = 4;

  logic        logic_clk;
  logic        logic_rst_n;
  logic [7:0]  mac_rdata_in;
  logic        mac_rvalid_in;
  logic        mac_rready_out;
  logic        mac_rlast_in;
  logic [1:0]  mac_rtype_in;
  logic [7:0]  ip_rdata_out;
  logic        ip_rvalid_out;
  logic        ip_rready_in;
  logic        ip_rlast_out;
  logic [7:0]  arp_rdata_out;
  logic        arp_rvalid_out;
  logic        arp_rready_in;
  logic        arp_rlast_out;
  logic [47:0] frame_src_mac_out;
  logic        frame_info_valid_out;
  logic        frame_drop_out;
  logic [1:0]  fsm_state_dbg;

  mac_rx_frame_demux dut (
    .logic_clk            (logic_clk),
    .logic_rst_n          (logic_rst_n),
    .mac_rdata_in         (mac_rdata_in),
    .mac_rvalid_in        (mac_rvalid_in),
    .mac_rready_out       (mac_rready_out),
    .mac_rlast_in         (mac_rlast_in),
    .mac_rtype_in         (mac_rtype_in),
    .ip_rdata_out         (ip_rdata_out),
    .ip_rvalid_out        (ip_rvalid_out),
    .ip_rready_in         (ip_rready_in),
    .ip_rlast_out         (ip_rlast_out),
    .arp_rdata_out        (arp_rdata_out),
    .arp_rvalid_out       (arp_rvalid_out),
    .arp_rready_in        (arp_rready_in),
    .arp_rlast_out        (arp_rlast_out),
    .frame_src_mac_out    (frame_src_mac_out),
    .frame_info_valid_out (frame_info_valid_out),
    .frame_drop_out       (frame_drop_out),
    .fsm_state_dbg        (fsm_state_dbg)
  );

  // Clock / reset
  initial begin
    logic_clk = 1'b0;
    forever #5 logic_clk = ~logic_clk;
  end

  int          total = 0;
  int          bad   = 0;
  logic [8:0]  exp_ip_q[$];
  logic [8:0]  exp_arp_q[$];
  logic [7:0]  frame_q[$];
  int          exp_drop = 0;
  int          exp_info = 0;
  int          obs_drop = 0;
  int          obs_info = 0;
  logic [47:0] mac_model = '0;
  int          sink_mode = 0;
  logic [9:0]  ip_e;
  logic [9:0]  arp_e;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sink readiness: 0 always ready, 1 toggling, 2 random
  always @(posedge logic_clk) begin
    #1;
    case (sink_mode)
      0: begin ip_rready_in = 1'b1; arp_rready_in = 1'b1; end
      1: begin ip_rready_in = ~ip_rready_in; arp_rready_in = ~arp_rready_in; end
      default: begin
        ip_rready_in  = 1'($urandom_range(0, 1));
        arp_rready_in = 1'($urandom_range(0, 1));
      end
    endcase
  end

  // Scoreboard: outputs are sampled mid-cycle, when a valid&ready pair commits at the next edge
  always @(negedge logic_clk) begin
    if (logic_rst_n) begin
      if (ip_rvalid_out && ip_rready_in) begin
        ip_e = '0;
        if (exp_ip_q.size() > 0) ip_e = {1'b1, exp_ip_q.pop_front()};
        check_val("ip_byte", {1'b1, ip_rlast_out, ip_rdata_out}, ip_e);
      end
      if (arp_rvalid_out && arp_rready_in) begin
        arp_e = '0;
        if (exp_arp_q.size() > 0) arp_e = {1'b1, exp_arp_q.pop_front()};
        check_val("arp_byte", {1'b1, arp_rlast_out, arp_rdata_out}, arp_e);
      end
      if (frame_drop_out) obs_drop++;
      if (frame_info_valid_out) obs_info++;
    end
  end

  // Driver tasks
  task automatic build_frame(input int n, input logic [47:0] src, input bit counted);
    frame_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i >= 6 && i <= 11) b = src[8*(11-i) +: 8];
      if (counted && i >= HDR) b = 8'(i - HDR);
      frame_q.push_back(b);
    end
  endtask

  // Reference model: frame-level outcome from length, type tag and byte contents
  task automatic model_frame(input logic [1:0] typ);
    int n;
    n = frame_q.size();
    for (int i = 6; i <= 11 && i < n - 1; i++) mac_model = {mac_model[39:0], frame_q[i]};
    if (n <= HDR) begin
      exp_drop++;
    end else begin
      exp_info++;
      if (!(typ == 2'b10 || typ == 2'b01)) exp_drop++;
      else if (n - HDR - FCS < 1) exp_drop++;
      else begin
        for (int i = HDR; i < n - FCS; i++) begin
          if (typ == 2'b10) exp_ip_q.push_back({(i == n - FCS - 1), frame_q[i]});
          else exp_arp_q.push_back({(i == n - FCS - 1), frame_q[i]});
        end
      end
    end
  endtask

  task automatic drive_frame(input logic [1:0] typ, input int gap_pct, input int stop_at);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      bit acc;
      int waits;
      acc = 1'b0;
      waits = 0;
      if (i == stop_at) break;
      while (!acc) begin
        mac_rvalid_in = (int'($urandom_range(0, 99)) >= gap_pct);
        mac_rdata_in  = frame_q[i];
        mac_rlast_in  = (i == n - 1);
        mac_rtype_in  = typ;
        @(negedge logic_clk);
        acc = mac_rvalid_in && mac_rready_out;
        @(posedge logic_clk);
        #1;
        waits++;
        if (!acc && waits > 200) begin
          check_val("src_stall", waits, 0);
          mac_rvalid_in = 1'b0;
          return;
        end
      end
    end
    mac_rvalid_in = 1'b0;
    mac_rlast_in  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_ip_q.size() > 0 || exp_arp_q.size() > 0) && c < 1000) begin
      @(posedge logic_clk);
      c++;
    end
    check_val("drain_ip", exp_ip_q.size(), 0);
    check_val("drain_arp", exp_arp_q.size(), 0);
    repeat (4) @(posedge logic_clk);
    #1;
    check_val("drop_count", obs_drop, exp_drop);
    check_val("info_count", obs_info, exp_info);
    check_val("src_mac", frame_src_mac_out, mac_model);
  endtask

  task automatic run_frame(input int n, input logic [1:0] typ, input logic [47:0] src,
                           input bit counted, input int gap_pct);
    build_frame(n, src, counted);
    model_frame(typ);
    drive_frame(typ, gap_pct, -1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ip"}, {ip_rdata_out, ip_rvalid_out, ip_rlast_out}, 0);
    check_val({tag, "_arp"}, {arp_rdata_out, arp_rvalid_out, arp_rlast_out}, 0);
    check_val({tag, "_mac"}, frame_src_mac_out, 0);
    check_val({tag, "_pulses"}, {frame_info_valid_out, frame_drop_out}, 0);
    check_val({tag, "_rready"}, mac_rready_out, 0);
  endtask

  initial begin
    logic_rst_n   = 1'b0;
    mac_rdata_in  = '0;
    mac_rvalid_in = 1'b0;
    mac_rlast_in  = 1'b0;
    mac_rtype_in  = '0;
    ip_rready_in  = 1'b1;
    arp_rready_in = 1'b1;

    repeat (2) @(negedge logic_clk);
    check_outputs_zero("reset");
    @(posedge logic_clk);
    #1;
    logic_rst_n = 1'b1;
    @(negedge logic_clk);
    check_val("rready_after_reset", mac_rready_out, 1);
    check_val("state_after_reset", fsm_state_dbg, 0);
    @(posedge logic_clk);
    #1;

    // IP 46-byte counted payload, sink always ready
    sink_mode = 0;
    run_frame(HDR + 46 + FCS, 2'b10, 48'h001122334455, 1'b1, 0);
    drain();

    // ARP 28-byte payload
    run_frame(HDR + 28 + FCS, 2'b01, 48'h0A0B0C0D0E0F, 1'b1, 0);
    drain();

    // IP frame with toggling sink ready
    sink_mode = 1;
    run_frame(HDR + 46 + FCS, 2'b10, 48'h001122334455, 1'b1, 0);
    drain();
    sink_mode = 0;

    // Unknown types, runts and the smallest non-runt payload
    run_frame(64, 2'b00, 48'hDEADBEEF0001, 1'b0, 0);
    run_frame(40, 2'b11, 48'hDEADBEEF0002, 1'b0, 0);
    run_frame(16, 2'b10, 48'h123456789ABC, 1'b0, 0);
    drain();
    run_frame(10, 2'b10, 48'hCAFE00000010, 1'b0, 0);
    drain();
    run_frame(HDR + FCS, 2'b01, 48'h111111111111, 1'b0, 0);
    run_frame(HDR + FCS + 1, 2'b01, 48'h222222222222, 1'b0, 0);
    run_frame(HDR + FCS + 1, 2'b10, 48'h333333333333, 1'b0, 0);
    drain();

    // Back-to-back random frames with random gaps and random sink stalls
    sink_mode = 2;
    for (int f = 0; f < 30; f++) begin
      int r;
      logic [1:0] typ;
      r = int'($urandom_range(0, 5));
      typ = (r < 2) ? 2'b10 : (r < 4) ? 2'b01 : (r == 4) ? 2'b00 : 2'b11;
      run_frame(int'($urandom_range(8, 80)), typ, {$urandom, 16'($urandom)}, 1'b0, 20);
    end
    drain();

    // Reset in the middle of a payload, then a clean frame
    sink_mode = 0;
    build_frame(64, 48'hA0A1A2A3A4A5, 1'b1);
    for (int k = 0; k < 16; k++) exp_ip_q.push_back({1'b0, frame_q[HDR + k]});
    exp_info++;
    drive_frame(2'b10, 0, HDR + 20);
    repeat (3) @(posedge logic_clk);
    #1;
    check_val("pre_reset_ip_left", exp_ip_q.size(), 0);
    logic_rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge logic_clk);
    #1;
    logic_rst_n = 1'b1;
    mac_model = '0;
    @(negedge logic_clk);
    check_val("rready_after_midreset", mac_rready_out, 1);
    @(posedge logic_clk);
    #1;
    sink_mode = 2;
    run_frame(64, 2'b10, 48'h5A5A5A5A5A5A, 1'b0, 10);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    check_val("global_timeout", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
